varredura_display: RTL and testbench

VARREDURA_DISPLAY -- requirements
Module: varredura_display

---
 rtl/varredura_display.sv | 128 ++++++++++++
 tb/tb_varredura_display.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/varredura_display.sv
// varredura_display: 4-digit multiplexed display scanner with an error-message
// hold window. A prescaler divides the clock into digit slots, a 2-bit index
// walks the digits, and a two-state FSM shows a latched error code for
// HOLD_SCANS complete scans.
// Optional feature: define VARREDURA_PISCA_EN to blink the message
// (16 scans lit, 16 scans blank) while it is displayed.
module varredura_display #(
  parameter int DIV        = 50000,
  parameter int HOLD_SCANS = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       erro_valido,
  input  logic [1:0] erro_cod,
  output logic       erro_aceito,
  output logic       saida1Contador,
  output logic       saida2Contador,
  output logic [3:0] digito,
  output logic       apagar,
  output logic       ocupado,
  output logic [1:0] codigo
);

  // Prescaler only needs to reach DIV-1.
  localparam int PRESC_W = (DIV > 2) ? $clog2(DIV) : 1;

  // Scan counter must reach HOLD_SCANS; with blinking it also needs bit 4,
  // which simply stays 0 (always lit) when HOLD_SCANS < 16.
`ifdef VARREDURA_PISCA_EN
  localparam int SCAN_W = ($clog2(HOLD_SCANS + 1) > 5) ? $clog2(HOLD_SCANS + 1) : 5;
`else
  localparam int SCAN_W = $clog2(HOLD_SCANS + 1);
`endif

  typedef enum logic {
    OCIOSO,
    EXIBINDO
  } estado_t;

  estado_t             state;
  estado_t             state_next;
  logic [PRESC_W-1:0]  presc;
  logic [1:0]          index;
  logic [SCAN_W-1:0]   scan;
  logic                tick;
  logic                wrap;
  logic                accept;
  logic                finish;

  // One digit slot ends when the prescaler reaches DIV-1; a full scan ends
  // when that happens on the last digit.
  assign tick = (presc == PRESC_W'(DIV - 1));
  assign wrap = tick && (index == 2'd3);

  // Digit select and enable follow the index in every state.
  assign saida1Contador = index[1];
  assign saida2Contador = index[0];
  assign digito         = ~(4'b0001 << index);

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) state <= OCIOSO;
    else       state <= state_next;
  end

  // Next-state logic and state-dependent outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    ocupado    = 1'b0;
    apagar     = 1'b1;
    unique case (state)
      OCIOSO: begin
        if (erro_valido) begin
          accept     = 1'b1;
          state_next = EXIBINDO;
        end
      end
      EXIBINDO: begin
        ocupado = 1'b1;
`ifdef VARREDURA_PISCA_EN
        apagar  = scan[4];
`else
        apagar  = 1'b0;
`endif
        // Last scan of the window completes: leave on this very edge.
        if (wrap && (scan == SCAN_W'(HOLD_SCANS - 1))) begin
          finish     = 1'b1;
          state_next = OCIOSO;
        end
      end
      default: state_next = OCIOSO;
    endcase
  end

  // Scan datapath: prescaler, digit index, scan counter, code latch and ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc       <= '0;
      index       <= '0;
      scan        <= '0;
      codigo      <= '0;
      erro_aceito <= 1'b0;
    end else begin
      erro_aceito <= accept;
      if (accept) begin
        // A new message restarts the scan from digit 0 so it is shown whole.
        codigo <= erro_cod;
        presc  <= '0;
        index  <= '0;
        scan   <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) index <= index + 1'b1;
        if (finish)
          scan <= '0;
        else if ((state == EXIBINDO) && wrap)
          scan <= scan + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_varredura_display.sv
// tb_varredura_display: randomized and directed checks of varredura_display
// against a cycle-count model (elapsed cycles since the last scan restart).
// Honours VARREDURA_PISCA_EN the same way as the design.
module tb_varredura_display;

  localparam int DIV        = 4;
  localparam int HOLD_SCANS = 2;
  localparam int SCAN_CYC   = 4 * DIV;
  localparam int HOLD_CYC   = HOLD_SCANS * SCAN_CYC;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       erro_valido = 1'b0;
  logic [1:0] erro_cod = 2'b00;
  logic       erro_aceito;
  logic       saida1Contador;
  logic       saida2Contador;
  logic [3:0] digito;
  logic       apagar;
  logic       ocupado;
  logic [1:0] codigo;

  int errors = 0;
  int checks = 0;

  // Reference model: busy flag, cycles since the last restart, code, ack.
  logic       m_busy = 1'b0;
  int         m_t    = 0;
  logic [1:0] m_code = 2'b00;
  logic       m_ack  = 1'b0;

  varredura_display #(.DIV(DIV), .HOLD_SCANS(HOLD_SCANS)) dut (
    .clock          (clock),
    .reset          (reset),
    .erro_valido    (erro_valido),
    .erro_cod       (erro_cod),
    .erro_aceito    (erro_aceito),
    .saida1Contador (saida1Contador),
    .saida2Contador (saida2Contador),
    .digito         (digito),
    .apagar         (apagar),
    .ocupado        (ocupado),
    .codigo         (codigo)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] exp_index();
    return 2'((m_t / DIV) % 4);
  endfunction

  function automatic logic [3:0] exp_digito();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << exp_index());
  endfunction

  function automatic logic exp_apagar();
    if (!m_busy) return 1'b1;
`ifdef VARREDURA_PISCA_EN
    return 1'(((m_t / SCAN_CYC) / 16) % 2);
`else
    return 1'b0;
`endif
  endfunction

  // Drive inputs, take one clock edge, advance the model, sample 1 time unit later.
  task automatic step(input logic r, input logic v, input logic [1:0] c);
    reset       = r;
    erro_valido = v;
    erro_cod    = c;
    @(posedge clock);
    if (r) begin
      m_busy = 1'b0; m_t = 0; m_code = 2'b00; m_ack = 1'b0;
    end else if (!m_busy && v) begin
      m_busy = 1'b1; m_t = 0; m_code = c; m_ack = 1'b1;
    end else begin
      m_ack = 1'b0;
      m_t   = m_t + 1;
      if (m_busy && m_t == HOLD_CYC) begin
        m_busy = 1'b0;
        m_t    = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 2'b11);
    checks++;
    if ({digito, saida1Contador, saida2Contador, apagar, ocupado, erro_aceito, codigo}
        !== {4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_outputs: got dig=%b s1=%b s2=%b apg=%b ocp=%b ack=%b cod=%b expected dig=1110 s1=0 s2=0 apg=1 ocp=0 ack=0 cod=00",
               digito, saida1Contador, saida2Contador, apagar, ocupado, erro_aceito, codigo);
    end
  endtask

  task automatic test_idle_scan();
    step(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({saida1Contador, saida2Contador} !== 2'((i / DIV) % 4) || digito !== exp_digito()) begin
        errors++;
        $display("FAIL idle_index cycle %0d: got idx=%0d dig=%b expected idx=%0d dig=%b",
                 i, {saida1Contador, saida2Contador}, digito, (i / DIV) % 4, exp_digito());
      end
      checks++;
      if (apagar !== 1'b1 || ocupado !== 1'b0) begin
        errors++;
        $display("FAIL idle_flags cycle %0d: got apg=%b ocp=%b expected apg=1 ocp=0", i, apagar, ocupado);
      end
      step(1'b0, 1'b0, 2'b00);
    end
  endtask

  task automatic test_accept();
    step(1'b0, 1'b1, 2'b10);
    checks++;
    if ({erro_aceito, codigo, ocupado, saida1Contador, saida2Contador, apagar}
        !== {1'b1, 2'b10, 1'b1, 2'b00, exp_apagar()}) begin
      errors++;
      $display("FAIL accept: got ack=%b cod=%b ocp=%b idx=%b apg=%b expected ack=1 cod=10 ocp=1 idx=00 apg=%b",
               erro_aceito, codigo, ocupado, {saida1Contador, saida2Contador}, apagar, exp_apagar());
    end
    step(1'b0, 1'b0, 2'b01);
    checks++;
    if (erro_aceito !== 1'b0 || codigo !== 2'b10) begin
      errors++;
      $display("FAIL ack_one_cycle: got ack=%b cod=%b expected ack=0 cod=10", erro_aceito, codigo);
    end
  endtask

  task automatic test_hold_duration();
    int n;
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 2'b01);
    n = 0;
    while (ocupado === 1'b1 && n < 10 * HOLD_CYC) begin
      n++;
      step(1'b0, 1'b0, 2'b11);
    end
    checks++;
    if (n != HOLD_CYC) begin
      errors++;
      $display("FAIL hold_duration: got %0d busy cycles expected %0d", n, HOLD_CYC);
    end
    checks++;
    if (apagar !== 1'b1 || ocupado !== 1'b0 || codigo !== 2'b01) begin
      errors++;
      $display("FAIL after_hold: got apg=%b ocp=%b cod=%b expected apg=1 ocp=0 cod=01", apagar, ocupado, codigo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int acks;
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 2'b10);
    acks = 0;
    n    = 0;
    while (ocupado === 1'b1 && n < 10 * HOLD_CYC) begin
      step(1'b0, 1'b1, 2'b01);
      n++;
      if (erro_aceito === 1'b1) acks++;
      if (ocupado === 1'b1 && codigo !== 2'b10) begin
        checks++;
        errors++;
        $display("FAIL held_code cycle %0d: got cod=%b expected cod=10", n, codigo);
      end
    end
    checks++;
    if (acks != 0 || n != HOLD_CYC) begin
      errors++;
      $display("FAIL held_ignored: got acks=%0d cycles=%0d expected acks=0 cycles=%0d", acks, n, HOLD_CYC);
    end
    step(1'b0, 1'b1, 2'b01);
    checks++;
    if (erro_aceito !== 1'b1 || codigo !== 2'b01 || ocupado !== 1'b1) begin
      errors++;
      $display("FAIL reaccept: got ack=%b cod=%b ocp=%b expected ack=1 cod=01 ocp=1", erro_aceito, codigo, ocupado);
    end
    step(1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 2'b11);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b1, 2'b10);
    checks++;
    if ({digito, saida1Contador, saida2Contador, apagar, ocupado, erro_aceito, codigo}
        !== {4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid: got dig=%b idx=%b apg=%b ocp=%b ack=%b cod=%b expected dig=1110 idx=00 apg=1 ocp=0 ack=0 cod=00",
               digito, {saida1Contador, saida2Contador}, apagar, ocupado, erro_aceito, codigo);
    end
    step(1'b0, 1'b1, 2'b10);
    checks++;
    if (erro_aceito !== 1'b1 || codigo !== 2'b10 || ocupado !== 1'b1) begin
      errors++;
      $display("FAIL accept_after_reset: got ack=%b cod=%b ocp=%b expected ack=1 cod=10 ocp=1", erro_aceito, codigo, ocupado);
    end
    step(1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_random();
    logic r;
    logic v;
    logic [1:0] c;
    step(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 30);
      c = 2'($urandom_range(0, 3));
      step(r, v, c);
      checks++;
      if ({erro_aceito, saida1Contador, saida2Contador, digito, apagar, ocupado, codigo}
          !== {m_ack, exp_index(), exp_digito(), exp_apagar(), m_busy, m_code}) begin
        errors++;
        $display("FAIL random cycle %0d: got ack=%b idx=%b dig=%b apg=%b ocp=%b cod=%b expected ack=%b idx=%b dig=%b apg=%b ocp=%b cod=%b",
                 i, erro_aceito, {saida1Contador, saida2Contador}, digito, apagar, ocupado, codigo,
                 m_ack, exp_index(), exp_digito(), exp_apagar(), m_busy, m_code);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_idle_scan();
    test_accept();
    test_hold_duration();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
